fetch_unit: RTL and testbench

- Instruction-fetch stage of the pipelined CPU; sits upstream of decode (IF/ID) and drives the instruction memory.
- Holds the PC and issues sequential fetches to a synchronous-read instruction memory with 1-cycle latency.
- Buffers returned words in a small prefetch queue and presents them to decode with a valid/ready handshake.
- Accepts branch/jump redirects from EX and flushes all wrong-path state.

---
 rtl/fetch_unit_if.sv | 24 ++
 rtl/fetch_unit.sv | 139 +++++++++++++
 tb/tb_fetch_unit.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch stage bus: instruction memory port, redirect input, decode handshake
// master = fetch unit side, slave = memory/EX/decode environment side.
interface fetch_unit_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_data_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;

  modport master (
    output imem_req_o, imem_addr_o, valid_o, inst_o, pc_o, pc_plus4_o,
    input  imem_data_i, redirect_i, redirect_pc_i, ready_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, valid_o, inst_o, pc_o, pc_plus4_o,
    output imem_data_i, redirect_i, redirect_pc_i, ready_i
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch: PC, 1-cycle imem issue, prefetch queue, redirect flush
// Optional FETCH_PERF_EN adds saturating fetch/stall/flush counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  fetch_unit_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]  perf_fetch_o,
  output logic [31:0]  perf_stall_o,
  output logic [31:0]  perf_flush_o
`endif
);
  localparam int            CW      = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] count_q, count_d;
  logic          inflight_q, inflight_d;
  logic [31:0]   inflight_pc_q, inflight_pc_d;
  logic [31:0]   inst_q [DEPTH];
  logic [31:0]   inst_d [DEPTH];
  logic [31:0]   qpc_q [DEPTH];
  logic [31:0]   qpc_d [DEPTH];
  logic [31:0]   plus4_q, plus4_d;

  logic          valid, pop, push, issue, head_change;
  logic [CW-1:0] occ, wr_idx;
  logic          unused_rpc_lsb;

  assign unused_rpc_lsb = ^bus.redirect_pc_i[1:0];

  // count+inflight never exceeds DEPTH, so every returning word has a free slot.
  always_comb begin
    valid = (count_q != '0);
    pop   = valid && bus.ready_i && !bus.redirect_i;
    push  = inflight_q && !bus.redirect_i;
    occ   = count_q + CW'(inflight_q);
    issue = !rst_i && !bus.redirect_i &&
            ((occ < DEPTH_C) || ((occ == DEPTH_C) && pop));
  end

  always_comb begin
    inst_d = inst_q;
    qpc_d  = qpc_q;
    wr_idx = count_q - CW'(pop);
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        inst_d[i] = inst_q[i + 1];
        qpc_d[i]  = qpc_q[i + 1];
      end
    end
    if (push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_idx == CW'(i)) begin
          inst_d[i] = bus.imem_data_i;
          qpc_d[i]  = inflight_pc_q;
        end
      end
    end
    count_d = bus.redirect_i ? '0 : (count_q + CW'(push) - CW'(pop));
    head_change = pop || (push && (wr_idx == '0));
    plus4_d = head_change ? (qpc_d[0] + 32'd4) : plus4_q;
  end

  always_comb begin
    if (bus.redirect_i) begin
      pc_d = {bus.redirect_pc_i[31:2], 2'b00};
    end else if (issue) begin
      pc_d = pc_q + 32'd4;
    end else begin
      pc_d = pc_q;
    end
    inflight_d    = issue;
    inflight_pc_d = pc_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q          <= {RESET_PC[31:2], 2'b00};
      count_q       <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      plus4_q       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        inst_q[i] <= '0;
        qpc_q[i]  <= '0;
      end
    end else begin
      pc_q          <= pc_d;
      count_q       <= count_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      plus4_q       <= plus4_d;
      inst_q        <= inst_d;
      qpc_q         <= qpc_d;
    end
  end

  assign bus.imem_req_o  = issue;
  assign bus.imem_addr_o = pc_q;
  assign bus.valid_o     = valid;
  assign bus.inst_o      = inst_q[0];
  assign bus.pc_o        = qpc_q[0];
  assign bus.pc_plus4_o  = plus4_q;

`ifdef FETCH_PERF_EN
  logic [31:0] pf_fetch_q, pf_fetch_d;
  logic [31:0] pf_stall_q, pf_stall_d;
  logic [31:0] pf_flush_q, pf_flush_d;

  always_comb begin
    pf_fetch_d = pf_fetch_q + {31'd0, issue && (pf_fetch_q != '1)};
    pf_stall_d = pf_stall_q + {31'd0, valid && !bus.ready_i && (pf_stall_q != '1)};
    pf_flush_d = pf_flush_q + {31'd0, bus.redirect_i && (pf_flush_q != '1)};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pf_fetch_q <= '0;
      pf_stall_q <= '0;
      pf_flush_q <= '0;
    end else begin
      pf_fetch_q <= pf_fetch_d;
      pf_stall_q <= pf_stall_d;
      pf_flush_q <= pf_flush_d;
    end
  end

  assign perf_fetch_o = pf_fetch_q;
  assign perf_stall_o = pf_stall_q;
  assign perf_flush_o = pf_flush_q;
`else
  // counters absent; fetch behaviour is unchanged
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - fetch_unit bench: directed vector table plus randomized run against a queue model
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_unit_if bus ();

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch, perf_stall, perf_flush;
  logic [31:0] m_fetch, m_stall, m_flush;
`endif

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_o (perf_fetch),
    .perf_stall_o (perf_stall),
    .perf_flush_o (perf_flush)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit en_chk = 1'b0;

  // Reference: every unsquashed request becomes an entry visible two cycles later.
  typedef struct {
    logic [31:0] pc;
    int          avail;
  } ent_t;
  ent_t        mq[$];
  logic [31:0] m_pc;

  logic        s_req, s_valid;
  logic [31:0] s_addr, s_inst, s_pc, s_p4;

  typedef struct {
    logic        rst;
    logic        redir;
    logic [31:0] rpc;
    logic        rdy;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic        exp_zero;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    bit          exp_valid, exp_pop, exp_req;
    bit          p_req;
    logic [31:0] p_addr;
    ent_t        e;
    #1;
    s_req   = bus.imem_req_o;
    s_addr  = bus.imem_addr_o;
    s_valid = bus.valid_o;
    s_inst  = bus.inst_o;
    s_pc    = bus.pc_o;
    s_p4    = bus.pc_plus4_o;
    exp_valid = (mq.size() > 0) && (mq[0].avail <= cyc);
    exp_pop   = exp_valid && bus.ready_i && !bus.redirect_i;
    exp_req   = !rst && !bus.redirect_i &&
                ((mq.size() < DEPTH) || ((mq.size() == DEPTH) && exp_pop));
    if (en_chk) begin
      chk("model_req", {31'd0, s_req}, {31'd0, exp_req});
      if (exp_req) chk("model_addr", s_addr, m_pc);
      chk("model_valid", {31'd0, s_valid}, {31'd0, exp_valid});
      if (exp_valid) begin
        chk("model_pc", s_pc, mq[0].pc);
        chk("model_inst", s_inst, mq[0].pc >> 2);
        chk("model_pc_plus4", s_p4, mq[0].pc + 32'd4);
      end
`ifdef FETCH_PERF_EN
      chk("perf_fetch", perf_fetch, m_fetch);
      chk("perf_stall", perf_stall, m_stall);
      chk("perf_flush", perf_flush, m_flush);
`endif
    end
`ifdef FETCH_PERF_EN
    m_fetch = m_fetch + {31'd0, exp_req};
    m_stall = m_stall + {31'd0, exp_valid && !bus.ready_i};
    m_flush = m_flush + {31'd0, bus.redirect_i};
    if (rst) begin
      m_fetch = 0; m_stall = 0; m_flush = 0;
    end
`endif
    if (rst) begin
      mq.delete();
      m_pc = RESET_PC;
    end else if (bus.redirect_i) begin
      mq.delete();
      m_pc = {bus.redirect_pc_i[31:2], 2'b00};
    end else begin
      if (exp_pop) void'(mq.pop_front());
      if (exp_req) begin
        e.pc = m_pc;
        e.avail = cyc + 2;
        mq.push_back(e);
        m_pc = m_pc + 32'd4;
      end
    end
    p_req  = s_req;
    p_addr = s_addr;
    cyc++;
    @(posedge clk);
    #1;
    bus.imem_data_i = p_req ? (p_addr >> 2) : $urandom();
    @(negedge clk);
  endtask

  function automatic void add(input logic r, input logic rd, input logic [31:0] rpc, input logic rdy,
                              input logic er, input logic [31:0] ea, input logic ev,
                              input logic [31:0] ep, input logic ez);
    vec_t v;
    v.rst = r; v.redir = rd; v.rpc = rpc; v.rdy = rdy;
    v.exp_req = er; v.exp_addr = ea; v.exp_valid = ev; v.exp_pc = ep; v.exp_zero = ez;
    tbl.push_back(v);
  endfunction

  initial begin
    rst = 1'b1;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = '0;
    bus.ready_i       = 1'b1;
    bus.imem_data_i   = '0;
`ifdef FETCH_PERF_EN
    m_fetch = 0; m_stall = 0; m_flush = 0;
`endif
    m_pc = RESET_PC;
    @(negedge clk);
    tick();
    tick();
    en_chk = 1'b1;

    //  rst  rd  rpc           rdy  req addr          vld pc            zero
    add(1, 0, 0,             1,   0, 0,             0, 0,             1);
    add(0, 0, 0,             1,   1, 32'h0,         0, 0,             0);
    add(0, 0, 0,             1,   1, 32'h4,         0, 0,             0);
    add(0, 0, 0,             1,   1, 32'h8,         1, 32'h0,         0);
    add(0, 0, 0,             1,   1, 32'hC,         1, 32'h4,         0);
    for (int i = 0; i < 5; i++)
      add(0, 0, 0,           0,   0, 0,             1, 32'h8,         0);
    add(0, 0, 0,             1,   1, 32'h10,        1, 32'h8,         0);
    add(0, 0, 0,             1,   1, 32'h14,        1, 32'hC,         0);
    add(0, 0, 0,             1,   1, 32'h18,        1, 32'h10,        0);
    add(0, 1, 32'h43,        1,   0, 0,             1, 32'h14,        0);
    add(0, 0, 0,             1,   1, 32'h40,        0, 0,             0);
    add(0, 0, 0,             1,   1, 32'h44,        0, 0,             0);
    add(0, 0, 0,             1,   1, 32'h48,        1, 32'h40,        0);
    add(0, 1, 32'h100,       1,   0, 0,             1, 32'h44,        0);
    add(0, 1, 32'h200,       1,   0, 0,             0, 0,             0);
    add(0, 0, 0,             1,   1, 32'h200,       0, 0,             0);
    add(0, 0, 0,             1,   1, 32'h204,       0, 0,             0);
    add(0, 0, 0,             1,   1, 32'h208,       1, 32'h200,       0);
    add(0, 1, 32'hFFFF_FFF8, 1,   0, 0,             1, 32'h204,       0);
    add(0, 0, 0,             1,   1, 32'hFFFF_FFF8, 0, 0,             0);
    add(0, 0, 0,             1,   1, 32'hFFFF_FFFC, 0, 0,             0);
    add(0, 0, 0,             1,   1, 32'h0,         1, 32'hFFFF_FFF8, 0);
    add(0, 0, 0,             1,   1, 32'h4,         1, 32'hFFFF_FFFC, 0);
    add(0, 0, 0,             1,   1, 32'h8,         1, 32'h0,         0);
    add(1, 0, 0,             1,   0, 0,             1, 32'h4,         0);
    add(1, 0, 0,             1,   0, 0,             0, 0,             1);
    add(0, 0, 0,             1,   1, 32'h0,         0, 0,             0);
    add(0, 0, 0,             1,   1, 32'h4,         0, 0,             0);
    add(0, 0, 0,             1,   1, 32'h8,         1, 32'h0,         0);

    foreach (tbl[n]) begin
      rst               = tbl[n].rst;
      bus.redirect_i    = tbl[n].redir;
      bus.redirect_pc_i = tbl[n].rpc;
      bus.ready_i       = tbl[n].rdy;
      tick();
      chk($sformatf("tbl%0d_req", n), {31'd0, s_req}, {31'd0, tbl[n].exp_req});
      if (tbl[n].exp_req) chk($sformatf("tbl%0d_addr", n), s_addr, tbl[n].exp_addr);
      chk($sformatf("tbl%0d_valid", n), {31'd0, s_valid}, {31'd0, tbl[n].exp_valid});
      if (tbl[n].exp_valid) begin
        chk($sformatf("tbl%0d_pc", n), s_pc, tbl[n].exp_pc);
        chk($sformatf("tbl%0d_inst", n), s_inst, tbl[n].exp_pc >> 2);
        chk($sformatf("tbl%0d_pc_plus4", n), s_p4, tbl[n].exp_pc + 32'd4);
      end
      if (tbl[n].exp_zero) begin
        chk($sformatf("tbl%0d_pc_zero", n), s_pc, 32'h0);
        chk($sformatf("tbl%0d_inst_zero", n), s_inst, 32'h0);
        chk($sformatf("tbl%0d_p4_zero", n), s_p4, 32'h0);
      end
    end

    for (int n = 0; n < 3000; n++) begin
      rst            = ($urandom_range(0, 99) < 2);
      bus.redirect_i = ($urandom_range(0, 99) < 6);
      case ($urandom_range(0, 2))
        0:       bus.redirect_pc_i = $urandom();
        1:       bus.redirect_pc_i = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: bus.redirect_pc_i = 32'($urandom_range(0, 255));
      endcase
      bus.ready_i = ($urandom_range(0, 99) < 65);
      tick();
    end

    rst = 1'b0;
    bus.redirect_i = 1'b0;
    bus.ready_i = 1'b1;
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
